// File: rtl/axi_burst_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_burst_slave
// Purpose  : AXI-style burst memory slave with independent read and write
//            channels. It supports FIXED, INCR and WRAP bursts of up to 256
//            beats, byte-lane write strobes, and SLVERR for illegal or
//            out-of-range bursts.
// Ports    : clk, rst                         clock, sync active-high reset
//            ar* / r*                         read address / read data channel
//            aw* / w* / b*                    write address / data / response
// Revision : 1.0  initial release
// ============================================================================
module axi_burst_slave #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 64,
    parameter int DEPTH  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     araddr,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [3:0]            arid,
    input  logic [1:0]            arbrust,
    input  logic [7:0]            arlen,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [3:0]            rid,
    output logic                  rlast,
    output logic [1:0]            rresp,
    input  logic [ADDR_W-1:0]     awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [3:0]            awid,
    input  logic [1:0]            awbrust,
    input  logic [7:0]            awlen,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic                  wlast,
    input  logic [DATA_W/8-1:0]   wstrb,
    output logic                  bvalid,
    input  logic                  bready,
    output logic [3:0]            bid,
    output logic [1:0]            bresp
);

    localparam int c_STRB_W = DATA_W / 8;
    localparam int c_LSB    = $clog2(c_STRB_W);
    localparam int c_WIDX_W = ADDR_W - c_LSB;   // width of a word index
    localparam int c_IDX_W  = $clog2(DEPTH);    // width of an array index
    localparam logic [c_WIDX_W:0] c_DEPTH = (c_WIDX_W + 1)'(DEPTH);

    localparam logic [1:0] c_FIXED  = 2'b00;
    localparam logic [1:0] c_INCR   = 2'b01;
    localparam logic [1:0] c_WRAP   = 2'b10;
    localparam logic [1:0] c_OKAY   = 2'b00;
    localparam logic [1:0] c_SLVERR = 2'b10;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;
    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    // A burst is rejected as a whole when its type is illegal or when the
    // highest word it touches lies beyond the array. For WRAP, len is 2^n-1,
    // so the highest word of the wrap window is simply idx | len.
    function automatic logic f_burst_err(input logic [c_WIDX_W-1:0] idx,
                                         input logic [1:0] burst,
                                         input logic [7:0] len);
        logic [c_WIDX_W-1:0] lenx;
        logic [c_WIDX_W:0]   top;
        logic                bad_type;
        lenx     = c_WIDX_W'(len);
        bad_type = (burst == 2'b11) ||
                   ((burst == c_WRAP) &&
                    !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15)));
        case (burst)
            c_FIXED: top = {1'b0, idx};
            c_INCR:  top = {1'b0, idx} + {1'b0, lenx};
            default: top = {1'b0, idx | lenx};
        endcase
        return bad_type || (top >= c_DEPTH);
    endfunction

    // Word index of the following beat. WRAP keeps the bits above the wrap
    // window and lets only the low bits (masked by len) roll over.
    function automatic logic [c_WIDX_W-1:0] f_next_idx(input logic [c_WIDX_W-1:0] idx,
                                                       input logic [1:0] burst,
                                                       input logic [7:0] len);
        logic [c_WIDX_W-1:0] lenx;
        lenx = c_WIDX_W'(len);
        case (burst)
            c_INCR:  return idx + c_WIDX_W'(1);
            c_WRAP:  return (idx & ~lenx) | ((idx + c_WIDX_W'(1)) & lenx);
            default: return idx;
        endcase
    endfunction

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    // ------------------------------------------------------------------ read
    logic [0:0]          r_rstate;
    logic [c_WIDX_W-1:0] r_ridx;
    logic [7:0]          r_rlen;
    logic [7:0]          r_rcnt;
    logic [1:0]          r_rburst;
    logic                r_rerr;
    logic [DATA_W-1:0]   r_rdata;
    logic [3:0]          r_rid;
    logic [1:0]          r_rresp;
    logic                r_rlast;

    logic [c_WIDX_W-1:0] w_ar_idx;
    logic                w_ar_err;
    logic [c_WIDX_W-1:0] w_rnext_idx;

    assign w_ar_idx    = araddr[ADDR_W-1:c_LSB];
    assign w_ar_err    = f_burst_err(w_ar_idx, arbrust, arlen);
    assign w_rnext_idx = f_next_idx(r_ridx, r_rburst, r_rlen);

    assign arready = (r_rstate == R_IDLE) && !rst;
    assign rvalid  = (r_rstate == R_DATA) && !rst;
    assign rdata   = r_rdata;
    assign rid     = r_rid;
    assign rresp   = r_rresp;
    assign rlast   = r_rlast;

    // rdata is captured from the array when a beat is set up, so it holds
    // steady under back-pressure and a same-cycle write cannot disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate <= R_IDLE;
            r_ridx   <= '0;
            r_rlen   <= '0;
            r_rcnt   <= '0;
            r_rburst <= c_FIXED;
            r_rerr   <= 1'b0;
            r_rdata  <= '0;
            r_rid    <= '0;
            r_rresp  <= c_OKAY;
            r_rlast  <= 1'b0;
        end else if (r_rstate == R_IDLE) begin
            if (arvalid) begin
                r_rstate <= R_DATA;
                r_ridx   <= w_ar_idx;
                r_rlen   <= arlen;
                r_rcnt   <= '0;
                r_rburst <= arbrust;
                r_rerr   <= w_ar_err;
                r_rid    <= arid;
                r_rresp  <= w_ar_err ? c_SLVERR : c_OKAY;
                r_rlast  <= (arlen == 8'd0);
                r_rdata  <= w_ar_err ? '0 : r_mem[w_ar_idx[c_IDX_W-1:0]];
            end
        end else if (rready) begin
            if (r_rlast) begin
                r_rstate <= R_IDLE;
                r_rlast  <= 1'b0;
            end else begin
                r_rcnt  <= r_rcnt + 8'd1;
                r_ridx  <= w_rnext_idx;
                r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
                r_rdata <= r_rerr ? '0 : r_mem[w_rnext_idx[c_IDX_W-1:0]];
            end
        end
    end

    // ----------------------------------------------------------------- write
    logic [1:0]          r_wstate;
    logic [c_WIDX_W-1:0] r_widx;
    logic [7:0]          r_wlen;
    logic [7:0]          r_wcnt;
    logic [1:0]          r_wburst;
    logic                r_werr;
    logic                r_wlast_err;
    logic [3:0]          r_wid;
    logic [3:0]          r_bid;
    logic [1:0]          r_bresp;

    logic [c_WIDX_W-1:0] w_aw_idx;
    logic                w_beat_final;
    logic                w_wlast_bad;
    logic                w_mem_we;

    assign w_aw_idx     = awaddr[ADDR_W-1:c_LSB];
    assign w_beat_final = (r_wcnt == r_wlen);
    assign w_wlast_bad  = (wlast != w_beat_final);

    assign awready  = (r_wstate == W_IDLE) && !rst;
    assign wready   = (r_wstate == W_DATA) && !rst;
    assign bvalid   = (r_wstate == W_RESP) && !rst;
    assign bid      = r_bid;
    assign bresp    = r_bresp;
    assign w_mem_we = wready && wvalid && !r_werr;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < c_STRB_W; b++) begin
                if (wstrb[b]) begin
                    r_mem[r_widx[c_IDX_W-1:0]][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate    <= W_IDLE;
            r_widx      <= '0;
            r_wlen      <= '0;
            r_wcnt      <= '0;
            r_wburst    <= c_FIXED;
            r_werr      <= 1'b0;
            r_wlast_err <= 1'b0;
            r_wid       <= '0;
            r_bid       <= '0;
            r_bresp     <= c_OKAY;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (awvalid) begin
                        r_wstate    <= W_DATA;
                        r_widx      <= w_aw_idx;
                        r_wlen      <= awlen;
                        r_wcnt      <= '0;
                        r_wburst    <= awbrust;
                        r_werr      <= f_burst_err(w_aw_idx, awbrust, awlen);
                        r_wlast_err <= 1'b0;
                        r_wid       <= awid;
                    end
                end
                W_DATA: begin
                    if (wvalid) begin
                        if (w_wlast_bad) begin
                            r_wlast_err <= 1'b1;
                        end
                        // The beat count alone ends the burst; wlast only
                        // affects the response code.
                        if (w_beat_final) begin
                            r_wstate <= W_RESP;
                            r_bid    <= r_wid;
                            r_bresp  <= (r_werr || r_wlast_err || w_wlast_bad) ? c_SLVERR : c_OKAY;
                        end else begin
                            r_wcnt <= r_wcnt + 8'd1;
                            r_widx <= f_next_idx(r_widx, r_wburst, r_wlen);
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        r_wstate <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Sub-word address bits do not select anything in a word-wide array.
    logic w_unused;
    assign w_unused = ^{araddr[c_LSB-1:0], awaddr[c_LSB-1:0]};

endmodule
`default_nettype wire

// File: doc/axi_burst_slave.md
AXI_BURST_SLAVE -- requirements
Module: axi_burst_slave
Interface
REQ-001 SHALL have parameter DATA_W, default 32: data bus width in bits; 32 or 64 only.
REQ-002 SHALL have parameter ADDR_W, default 64: address width in bits.
REQ-003 SHALL have parameter DEPTH, default 1024: number of DATA_W-bit words in the internal array.
REQ-004 SHALL have port clk  in  1  clock; all logic on posedge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port araddr  in  ADDR_W  read burst start byte address.
REQ-007 SHALL have port arvalid  in  1  read address valid.
REQ-008 SHALL have port arready  out  1  read address ready.
REQ-009 SHALL have port arid  in  4  read transaction ID.
REQ-010 SHALL have port arbrust  in  2  read burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
REQ-011 SHALL have port arlen  in  8  read beats minus one.
REQ-012 SHALL have port rdata  out  DATA_W  read data.
REQ-013 SHALL have port rvalid  out  1  read data valid.
REQ-014 SHALL have port rready  in  1  read data accept.
REQ-015 SHALL have port rid  out  4  echo of latched arid.
REQ-016 SHALL have port rlast  out  1  final read beat.
REQ-017 SHALL have port rresp  out  2  00 OKAY, 10 SLVERR.
REQ-018 SHALL have port awaddr  in  ADDR_W  write burst start byte address.
REQ-019 SHALL have port awvalid  in  1  write address valid.
REQ-020 SHALL have port awready  out  1  write address ready.
REQ-021 SHALL have port awid  in  4  write transaction ID.
REQ-022 SHALL have port awbrust  in  2  write burst type; encoding as arbrust.
REQ-023 SHALL have port awlen  in  8  write beats minus one.
REQ-024 SHALL have port wdata  in  DATA_W  write data.
REQ-025 SHALL have port wvalid  in  1  write data valid.
REQ-026 SHALL have port wready  out  1  write data ready.
REQ-027 SHALL have port wlast  in  1  master-flagged final write beat.
REQ-028 SHALL have port wstrb  in  DATA_W/8  byte-lane enables.
REQ-029 SHALL have port bvalid  out  1  write response valid.
REQ-030 SHALL have port bready  in  1  write response accept.
REQ-031 SHALL have port bid  out  4  echo of latched awid.
REQ-032 SHALL have port bresp  out  2  00 OKAY, 10 SLVERR.
Function
REQ-033 Read FSM SHALL have states R_IDLE and R_DATA; arready=1 only in R_IDLE; arvalid&&arready latches addr/id/len/burst and enters R_DATA the next cycle.
REQ-034 In R_DATA, rvalid=1 and rdata=mem[word index of current address]; a beat completes on rvalid&&rready; rdata/rid/rresp/rlast hold while rvalid&&!rready.
REQ-035 rlast=1 iff beat count==latched len; completion of the last beat returns to R_IDLE; arready reasserts the following cycle (no back-to-back acceptance).
REQ-036 Address step per beat SHALL be: FIXED, no change; INCR, +DATA_W/8 bytes; WRAP, increment wrapping at a (len+1)*DATA_W/8-byte aligned boundary.
REQ-037 A burst SHALL be SLVERR on every beat when type is 11, when WRAP has len not in {1,3,7,15}, or when any beat's word index >= DEPTH; such read beats return rdata=0.
REQ-038 Write FSM SHALL have states W_IDLE, W_DATA and W_RESP; awready=1 only in W_IDLE; wready=1 only in W_DATA; bvalid=1 only in W_RESP.
REQ-039 Each W_DATA beat with wvalid SHALL update only byte lanes whose wstrb bit is 1; SLVERR beats SHALL write nothing.
REQ-040 The write beat with count==len SHALL move to W_RESP; wlast mismatch on any beat SHALL force bresp=10; W_RESP exits to W_IDLE on bready.
REQ-041 Read and write FSMs SHALL run independently; a same-cycle read beat and write beat to one word SHALL return the pre-write data.
REQ-042 A 256-beat burst (len=255) SHALL be supported; the beat counter is 8 bits and does not wrap within a burst.
Reset
REQ-043 While rst=1: both FSMs go to idle; arready, awready, wready, rvalid, rlast, bvalid=0; rresp, bresp, rid, bid=0; array contents are not reset.
REQ-044 arready and awready SHALL be 1 in the first cycle after rst falls; rst asserted mid-burst aborts the burst with no response.
Verification
REQ-045 INCR write addr 0x10, len=3, wstrb=F, data 1..4 -> bresp=00; INCR read of the same -> 1,2,3,4, rlast on beat 4 only.
REQ-046 WRAP read addr 0x18, len=3, DATA_W=32 -> word addresses 0x18,0x1C,0x10,0x14.
REQ-047 Read with rready low for 5 cycles mid-burst -> rdata stable, no beat skipped or repeated.
REQ-048 Write wstrb=0x1 data 0xAABBCCDD over 0x11223344 -> readback 0x112233DD.
REQ-049 Read at word index DEPTH, len=1 -> two beats, rresp=10, rdata=0; arbrust=11 write -> bresp=10, array unchanged.
